lcb_rx_unpacker: RTL and testbench



---
 rtl/lcb_rx_unpacker.sv | 229 ++++++++++++++++++++++
 tb/tb_lcb_rx_unpacker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcb_rx_unpacker.sv
// LCB response unpacker: frames a packet, checks its header, packs payload into 12-bit words.
// Optional trailing XOR checksum byte is enabled with LCB_RX_CHECKSUM_EN.
module lcb_rx_unpacker #(
    parameter int         FAST_BYTES = 6,
    parameter int         SLOW_BYTES = 3,
    parameter logic [7:0] HEADER     = 8'hA5,
    parameter int         TIMEOUT    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rstTx,
    input  logic [7:0]  iData,
    input  logic        strob,
    output logic [11:0] fData,
    output logic        fVal,
    output logic [11:0] sData,
    output logic        sVal,
    output logic        pktDone,
    output logic        pktErr,
    output logic [7:0]  errCnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [15:0] FAST_LAST = 16'(FAST_BYTES - 1);
    localparam logic [15:0] SLOW_LAST = 16'((SLOW_BYTES > 0) ? SLOW_BYTES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        FAST,
        SLOW
`ifdef LCB_RX_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t      state, state_n;
    logic [15:0] idx, idx_n;
    logic [1:0]  phase, phase_n;
    logic [7:0]  b0, b0_n;
    logic [3:0]  nib, nib_n;
    logic [TW-1:0] timer, timer_n;
    logic [11:0] fdata_n, sdata_n;
    logic        fval_n, sval_n, done_n, err_n;
    logic [7:0]  errcnt_n;
    logic [11:0] word;
    logic        emit, bump, pkt_end, abort;
`ifdef LCB_RX_CHECKSUM_EN
    logic [7:0]  chk, chk_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            phase   <= '0;
            b0      <= '0;
            nib     <= '0;
            timer   <= '0;
            fData   <= '0;
            sData   <= '0;
            fVal    <= 1'b0;
            sVal    <= 1'b0;
            pktDone <= 1'b0;
            pktErr  <= 1'b0;
            errCnt  <= '0;
`ifdef LCB_RX_CHECKSUM_EN
            chk     <= '0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            phase   <= phase_n;
            b0      <= b0_n;
            nib     <= nib_n;
            timer   <= timer_n;
            fData   <= fdata_n;
            sData   <= sdata_n;
            fVal    <= fval_n;
            sVal    <= sval_n;
            pktDone <= done_n;
            pktErr  <= err_n;
            errCnt  <= errcnt_n;
`ifdef LCB_RX_CHECKSUM_EN
            chk     <= chk_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        phase_n  = phase;
        b0_n     = b0;
        nib_n    = nib;
        timer_n  = timer;
        fdata_n  = fData;
        sdata_n  = sData;
        fval_n   = 1'b0;
        sval_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        errcnt_n = errCnt;
        word     = '0;
        emit     = 1'b0;
        bump     = 1'b0;
        pkt_end  = 1'b0;
        abort    = 1'b0;
`ifdef LCB_RX_CHECKSUM_EN
        chk_n    = chk;
`endif
        if (rstTx) begin
            // Resync drops everything in flight, including a coincident byte
            state_n = IDLE;
            idx_n   = '0;
            phase_n = '0;
            b0_n    = '0;
            nib_n   = '0;
            timer_n = '0;
`ifdef LCB_RX_CHECKSUM_EN
            chk_n   = '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    timer_n = '0;
                    if (strob) begin
                        if (iData == HEADER) begin
                            state_n = FAST;
                            idx_n   = '0;
                            phase_n = '0;
`ifdef LCB_RX_CHECKSUM_EN
                            chk_n   = HEADER;
`endif
                        end else begin
                            bump = 1'b1;
                        end
                    end
                end
                FAST, SLOW: begin
                    if (strob) begin
                        timer_n = '0;
                        idx_n   = idx + 16'd1;
`ifdef LCB_RX_CHECKSUM_EN
                        chk_n   = chk ^ iData;
`endif
                        case (phase)
                            2'd0: begin
                                b0_n    = iData;
                                phase_n = 2'd1;
                            end
                            2'd1: begin
                                word    = {b0, iData[7:4]};
                                nib_n   = iData[3:0];
                                emit    = 1'b1;
                                phase_n = 2'd2;
                            end
                            default: begin
                                word    = {nib, iData};
                                emit    = 1'b1;
                                phase_n = 2'd0;
                            end
                        endcase
                        if (state == FAST) begin
                            fval_n = emit;
                            if (emit) fdata_n = word;
                        end else begin
                            sval_n = emit;
                            if (emit) sdata_n = word;
                        end
                        if (state == FAST && idx == FAST_LAST) begin
                            idx_n   = '0;
                            phase_n = '0;
                            if (SLOW_BYTES > 0) state_n = SLOW;
                            else pkt_end = 1'b1;
                        end else if (state == SLOW && idx == SLOW_LAST) begin
                            idx_n   = '0;
                            phase_n = '0;
                            pkt_end = 1'b1;
                        end
                    end else if (timer == TMAX) begin
                        abort = 1'b1;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
`ifdef LCB_RX_CHECKSUM_EN
                CHK: begin
                    if (strob) begin
                        timer_n = '0;
                        state_n = IDLE;
                        if (iData == chk) begin
                            done_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                            bump  = 1'b1;
                        end
                    end else if (timer == TMAX) begin
                        abort = 1'b1;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
            if (pkt_end) begin
`ifdef LCB_RX_CHECKSUM_EN
                state_n = CHK;
`else
                done_n  = 1'b1;
                state_n = IDLE;
`endif
            end
            if (abort) begin
                err_n   = 1'b1;
                bump    = 1'b1;
                state_n = IDLE;
                idx_n   = '0;
                phase_n = '0;
                b0_n    = '0;
                nib_n   = '0;
                timer_n = '0;
            end
        end
        if (bump && errCnt != 8'hFF) errcnt_n = errCnt + 8'd1;
    end

endmodule

// File: tb/tb_lcb_rx_unpacker.sv
// Scoreboard bench for lcb_rx_unpacker: directed packets, errors, timeout, resync, reset.
// Builds with or without LCB_RX_CHECKSUM_EN.
module tb_lcb_rx_unpacker;

    logic        clk = 1'b0;
    logic        rst, rstTx, strob;
    logic [7:0]  iData;
    logic [11:0] fData, sData;
    logic        fVal, sVal, pktDone, pktErr;
    logic [7:0]  errCnt;

    always #5 clk = ~clk;

    lcb_rx_unpacker dut (
        .clk(clk), .rst(rst), .rstTx(rstTx), .iData(iData), .strob(strob),
        .fData(fData), .fVal(fVal), .sData(sData), .sVal(sVal),
        .pktDone(pktDone), .pktErr(pktErr), .errCnt(errCnt)
    );

    typedef struct {
        int          kind;
        logic [11:0] data;
    } ev_t;

    ev_t q[$];
    int checks = 0;
    int failures = 0;
    int exp_err = 0;

    logic [7:0]  pay[9] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11};
    logic [11:0] fw[4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
    logic [11:0] sw[2] = '{12'hDEF, 12'h011};

    task automatic push_ev(input int k, input logic [11:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic pop_check(input int k, input logic [11:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out kind=%0d data=%h required=none", k, d);
        end else begin
            e = q.pop_front();
            if (e.kind != k || (k < 2 && e.data != d)) begin
                failures++;
                $display("FAIL out_match got kind=%0d data=%h required kind=%0d data=%h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: kinds 0=fast word, 1=slow word, 2=pktDone, 3=pktErr
    always @(negedge clk) begin
        if (fVal || sVal) begin
            checks++;
            if (fVal && sVal) begin
                failures++;
                $display("FAIL val_excl got fVal=1 sVal=1 required not both");
            end
        end
        if (fVal) pop_check(0, fData);
        if (sVal) pop_check(1, sData);
`ifndef LCB_RX_CHECKSUM_EN
        if (pktDone) begin
            checks++;
            if (!(fVal || sVal)) begin
                failures++;
                $display("FAIL done_align got pktDone without Val required with final Val");
            end
        end
`endif
        if (pktDone) pop_check(2, 12'h0);
        if (pktErr) pop_check(3, 12'h0);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        iData = b;
        strob = 1'b1;
        @(negedge clk);
        strob = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_err(input string name);
        checks++;
        if (errCnt != 8'(exp_err)) begin
            failures++;
            $display("FAIL %s errCnt got %0d required %0d", name, errCnt, exp_err);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({fData, sData, fVal, sVal, pktDone, pktErr, errCnt} != '0) begin
            failures++;
            $display("FAIL %s got fData=%h sData=%h v=%b%b%b%b errCnt=%0d required all 0",
                     name, fData, sData, fVal, sVal, pktDone, pktErr, errCnt);
        end
    endtask

    task automatic send_pkt(input bit zero, input bit badchk);
        logic [7:0] c;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) push_ev(0, zero ? 12'h0 : fw[i]);
        for (int i = 0; i < 2; i++) push_ev(1, zero ? 12'h0 : sw[i]);
`ifdef LCB_RX_CHECKSUM_EN
        push_ev(badchk ? 3 : 2, 12'h0);
`else
        push_ev(2, 12'h0);
`endif
        send_byte(8'hA5);
        c = 8'hA5;
        for (int i = 0; i < 9; i++) begin
            b = zero ? 8'h00 : pay[i];
            c = c ^ b;
            send_byte(b);
        end
`ifdef LCB_RX_CHECKSUM_EN
        send_byte(badchk ? 8'h00 : c);
`endif
    endtask

    initial begin
        rst = 1'b1;
        rstTx = 1'b0;
        strob = 1'b0;
        iData = 8'h00;
        idle(3);
        check_reset("reset_state");
        rst = 1'b0;

        send_pkt(1'b0, 1'b0);
        idle(5);
        check_err("err_good_pkt");

        send_byte(8'h3C);
        exp_err++;
        send_pkt(1'b0, 1'b0);
        idle(5);
        check_err("err_bad_header");

        push_ev(0, 12'h123);
        push_ev(3, 12'h0);
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        exp_err++;
        idle(1010);
        check_err("err_timeout");
        send_pkt(1'b0, 1'b0);
        idle(5);
        check_err("err_after_timeout");

        push_ev(0, 12'h123);
        push_ev(0, 12'h456);
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        @(negedge clk);
        rstTx = 1'b1;
        strob = 1'b1;
        iData = 8'hA5;
        @(negedge clk);
        rstTx = 1'b0;
        strob = 1'b0;
        send_pkt(1'b0, 1'b0);
        idle(5);
        check_err("err_rsttx");

        send_byte(8'h00);
        exp_err++;
        idle(3);
        check_err("err_after_end");

`ifdef LCB_RX_CHECKSUM_EN
        send_pkt(1'b1, 1'b0);
        idle(5);
        check_err("err_chk_good");
        send_pkt(1'b1, 1'b1);
        exp_err++;
        idle(5);
        check_err("err_chk_bad");
`endif

        for (int i = 0; i < 260; i++) send_byte(8'h3C);
        exp_err = 255;
        idle(3);
        check_err("err_saturate");

        for (int i = 0; i < 4; i++) push_ev(0, fw[i]);
        send_byte(8'hA5);
        for (int i = 0; i < 7; i++) send_byte(pay[i]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("reset_mid_slow");
        rst = 1'b0;
        exp_err = 0;
        send_pkt(1'b0, 1'b0);
        idle(5);
        check_err("err_after_rst");

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got %0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
